// File: rtl/aes_pkg.sv
// Shared AES-128 primitives: S-box, byte/word transforms, MixColumns and the
// encryption sequencer's state encoding.
package aes_pkg;

   localparam int AES128_NR = 10;

   typedef enum logic [1:0] {
      IDLE,
      ROUND,
      FINAL,
      DONE
   } aes_fsm_e;

   // Byte x of the S-box lives at bits [8*(255-x)+7 -: 8], i.e. entry 0 is the MSB byte.
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX_TABLE[{~x, 3'b111} -: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int i = 0; i < 16; i++)
         r[8*i +: 8] = sbox(s[8*i +: 8]);
      return r;
   endfunction

   // Row r of column c takes the byte from column (c+r) mod 4; byte n sits at [127-8n -: 8].
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int c = 0; c < 4; c++)
         for (int row = 0; row < 4; row++)
            r[127 - 8*(4*c + row) -: 8] = s[127 - 8*(4*((c + row) % 4) + row) -: 8];
      return r;
   endfunction

   function automatic logic [31:0] sub_word_rot(input logic [31:0] w);
      return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] r;
      logic [7:0]   a0, a1, a2, a3;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127 - 32*c -: 8];
         a1 = s[119 - 32*c -: 8];
         a2 = s[111 - 32*c -: 8];
         a3 = s[103 - 32*c -: 8];
         r[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         r[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         r[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         r[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return r;
   endfunction

endpackage

// File: rtl/aes128_key_step.sv
// One step of the AES-128 key schedule: derives the next round key from the
// current one and the round constant.
module aes128_key_step
   import aes_pkg::*;
(
   input  logic [127:0] rk,
   input  logic [7:0]   rcon,
   output logic [127:0] rk_next
);

   logic [31:0] t;
   logic [31:0] n0, n1, n2, n3;

   assign t  = sub_word_rot(rk[31:0]) ^ {rcon, 24'h000000};
   assign n0 = rk[127:96] ^ t;
   assign n1 = rk[95:64]  ^ n0;
   assign n2 = rk[63:32]  ^ n1;
   assign n3 = rk[31:0]   ^ n2;

   assign rk_next = {n0, n1, n2, n3};

endmodule

// File: rtl/aes128_enc_sequencer.sv
// Iterative AES-128 encryptor: one round per clock with on-the-fly key expansion,
// valid/ready handshakes on the plaintext and ciphertext sides.
module aes128_enc_sequencer
   import aes_pkg::*;
#(
   parameter int NR = AES128_NR
)
(
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] pt_in,
   input  logic [127:0] key_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] ct_out,
   output logic         busy,
   output logic [3:0]   round_o,
   output logic [127:0] state_o
);

   aes_fsm_e     fsm;
   logic [127:0] rk;
   logic [7:0]   rcon;
   logic [127:0] rk_next;
   logic [127:0] sr_state;
   logic [127:0] round_val;
   logic [127:0] final_val;

   aes128_key_step u_key_step (
      .rk      (rk),
      .rcon    (rcon),
      .rk_next (rk_next)
   );

   assign sr_state  = shift_rows(sub_bytes(state_o));
   assign round_val = mix_columns(sr_state) ^ rk_next;
   assign final_val = sr_state ^ rk_next;

   // The debug state register doubles as the datapath state; ct_out is only
   // loaded in FINAL so it keeps the previous ciphertext until the next one.
   always_ff @(posedge clk) begin
      if (rst) begin
         fsm       <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         round_o   <= 4'd0;
         state_o   <= '0;
         ct_out    <= '0;
         rk        <= '0;
         rcon      <= 8'h00;
      end else begin
         case (fsm)
            IDLE: begin
               if (in_valid && in_ready) begin
                  state_o  <= pt_in ^ key_in;
                  rk       <= key_in;
                  rcon     <= 8'h01;
                  round_o  <= 4'd1;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  fsm      <= ROUND;
               end
            end
            ROUND: begin
               state_o <= round_val;
               rk      <= rk_next;
               rcon    <= xtime(rcon);
               round_o <= round_o + 4'd1;
               if (round_o == 4'(NR - 1))
                  fsm <= FINAL;
            end
            FINAL: begin
               state_o   <= final_val;
               ct_out    <= final_val;
               out_valid <= 1'b1;
               fsm       <= DONE;
            end
            DONE: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  round_o   <= 4'd0;
                  in_ready  <= 1'b1;
                  fsm       <= IDLE;
               end
            end
            default: fsm <= IDLE;
         endcase
      end
   end

endmodule
